// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: merges stage stall requests, sequences exception/ERET
// flushes with a redirect PC, and watches for pipelines held stalled too long.
module pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
    parameter logic [31:0] ERET_CODE    = 32'h0000000e,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned TIMEOUT      = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_valid,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    input  logic        timeout_clr,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic        busy
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t             state_reg, state_next;
    logic               flush_reg, flush_next;
    logic [31:0]        new_pc_reg, new_pc_next;
    logic [3:0]         fcnt_reg, fcnt_next;
    logic [CNT_W-1:0]   wd_cnt_reg, wd_cnt_next;
    logic               timeout_reg, timeout_next;

    // Stage-indexed requests; the pc stage never requests on its own.
    logic [4:0]         req;
    logic [4:0]         stop_raw;
    logic               wd_count;

    assign req = {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if, 1'b0};

    // A stage stops if it or any later stage (up to mem) is requesting; this
    // gives the highest-requester-wins encoding without an explicit priority chain.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_stop
            assign stop_raw[gi] = |req[4:gi];
        end
    endgenerate

    always_comb begin
        stall = 6'b000000;
        if (rst && state_reg == IDLE) begin
            stall = {1'b0, stop_raw};
        end
    end

    assign wd_count = (state_reg == IDLE) && stall[0];

    always_comb begin
        state_next   = state_reg;
        flush_next   = flush_reg;
        new_pc_next  = new_pc_reg;
        fcnt_next    = fcnt_reg;
        wd_cnt_next  = wd_cnt_reg;
        timeout_next = timeout_reg;

        case (state_reg)
            IDLE: begin
                if (exc_valid) begin
                    state_next  = FLUSH;
                    flush_next  = 1'b1;
                    fcnt_next   = 4'(FLUSH_CYCLES - 1);
                    new_pc_next = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
                end
            end
            FLUSH: begin
                if (fcnt_reg == 4'd0) begin
                    state_next = IDLE;
                    flush_next = 1'b0;
                end else begin
                    fcnt_next = fcnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                flush_next = 1'b0;
            end
        endcase

        // Saturating run-length of stalled IDLE cycles; the flag fires only on arrival.
        if (wd_count) begin
            if (wd_cnt_reg != CNT_W'(TIMEOUT)) begin
                wd_cnt_next = wd_cnt_reg + 1'b1;
            end
        end else begin
            wd_cnt_next = '0;
        end

        if (wd_count && wd_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            timeout_next = 1'b1;
        end else if (timeout_clr) begin
            timeout_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            flush_reg   <= 1'b0;
            new_pc_reg  <= 32'h0;
            fcnt_reg    <= 4'd0;
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            flush_reg   <= flush_next;
            new_pc_reg  <= new_pc_next;
            fcnt_reg    <= fcnt_next;
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign flush         = flush_reg;
    assign new_pc        = new_pc_reg;
    assign stall_timeout = timeout_reg;
    assign busy          = (state_reg == FLUSH);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: two instances (3-cycle and 1-cycle flush)
// driven by shared directed and random stimulus, checked against a cycle-level model.
module tb_pipeline_ctrl;

    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sif, sid, sex, smem, exc_valid, timeout_clr;
    logic [31:0] excepttype, cp0_epc;

    logic [5:0]  stall_o [2];
    logic        flush_o [2];
    logic        busy_o  [2];
    logic        to_o    [2];
    logic [31:0] pc_o    [2];

    pipeline_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(T)) u_dut_fc3 (
        .clk(clk), .rst(rst),
        .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
        .exc_valid(exc_valid), .excepttype(excepttype), .cp0_epc(cp0_epc),
        .timeout_clr(timeout_clr),
        .stall(stall_o[0]), .flush(flush_o[0]), .new_pc(pc_o[0]),
        .stall_timeout(to_o[0]), .busy(busy_o[0])
    );

    pipeline_ctrl #(.FLUSH_CYCLES(1), .TIMEOUT(T)) u_dut_fc1 (
        .clk(clk), .rst(rst),
        .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
        .exc_valid(exc_valid), .excepttype(excepttype), .cp0_epc(cp0_epc),
        .timeout_clr(timeout_clr),
        .stall(stall_o[1]), .flush(flush_o[1]), .new_pc(pc_o[1]),
        .stall_timeout(to_o[1]), .busy(busy_o[1])
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: remaining flush cycles, captured PC, stalled-run length, flag.
    int          fc [2] = '{3, 1};
    int          m_left [2];
    logic [31:0] m_pc [2];
    int          m_run [2];
    logic        m_to [2];

    function automatic logic [5:0] req_stall();
        if (smem) return 6'b011111;
        if (sex)  return 6'b001111;
        if (sid)  return 6'b000111;
        if (sif)  return 6'b000011;
        return 6'b000000;
    endfunction

    function automatic logic [5:0] exp_stall(input int k);
        return (m_left[k] > 0) ? 6'b000000 : req_stall();
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_pc[k] = 32'h0; m_run[k] = 0; m_to[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [5:0] s;
            logic       was_flush, set_to;
            s         = exp_stall(k);
            was_flush = (m_left[k] > 0);
            set_to    = !was_flush && s[0] && (m_run[k] == T - 1);
            if (!was_flush && s[0]) begin
                if (m_run[k] < T) m_run[k]++;
            end else begin
                m_run[k] = 0;
            end
            if (set_to)           m_to[k] = 1'b1;
            else if (timeout_clr) m_to[k] = 1'b0;
            if (was_flush) begin
                m_left[k]--;
            end else if (exc_valid) begin
                m_left[k] = fc[k];
                m_pc[k]   = (excepttype == 32'h0000000e) ? cp0_epc : 32'h00000020;
            end
        end
    endtask

    task automatic check_stall();
        for (int k = 0; k < 2; k++)
            check($sformatf("stall[%0d]", k), 32'(stall_o[k]), 32'(exp_stall(k)));
    endtask

    task automatic check_regs();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("flush[%0d]", k), 32'(flush_o[k]), 32'(m_left[k] > 0));
            check($sformatf("busy[%0d]", k),  32'(busy_o[k]),  32'(m_left[k] > 0));
            check($sformatf("new_pc[%0d]", k), pc_o[k], m_pc[k]);
            check($sformatf("timeout[%0d]", k), 32'(to_o[k]), 32'(m_to[k]));
        end
    endtask

    // Called at posedge+1 with fresh inputs; returns at the following posedge+1.
    task automatic cycle();
        #1;
        check_stall();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_stall[%0d]", tag, k), 32'(stall_o[k]), 32'h0);
            check($sformatf("%s_flush[%0d]", tag, k), 32'(flush_o[k]), 32'h0);
            check($sformatf("%s_busy[%0d]", tag, k),  32'(busy_o[k]),  32'h0);
            check($sformatf("%s_pc[%0d]", tag, k),    pc_o[k],          32'h0);
            check($sformatf("%s_to[%0d]", tag, k),    32'(to_o[k]),     32'h0);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #3;
        rst = 1'b0;
        #1;
        check_zero("arst");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("arst_hold");
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        {sif, sid, sex, smem, exc_valid, timeout_clr} = '0;
        excepttype = 32'h0; cp0_epc = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        smem = 1'b1;
        #1;
        check_zero("reset");
        smem = 1'b0;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Combinational stall priority, no clock between changes.
        sid = 1'b1;
        #1 check("prio_id", 32'(stall_o[0]), 32'h07);
        smem = 1'b1;
        #1 check("prio_mem", 32'(stall_o[0]), 32'h1f);
        {sif, sid, sex, smem} = '0;
        #1 check("prio_none", 32'(stall_o[1]), 32'h00);

        // Plain exception.
        excepttype = 32'h00000001; cp0_epc = 32'h12345678; exc_valid = 1'b1;
        cycle();
        check("exc_pc", pc_o[1], 32'h00000020);
        exc_valid = 1'b0;
        repeat (4) cycle();
        check("exc_pc_hold", pc_o[1], 32'h00000020);

        // ERET with a second exc_valid ignored mid-flush and stall masked.
        excepttype = 32'h0000000e; cp0_epc = 32'h00401234; exc_valid = 1'b1;
        cycle();
        check("eret_pc", pc_o[0], 32'h00401234);
        exc_valid = 1'b0; sex = 1'b1;
        cycle();
        exc_valid = 1'b1; excepttype = 32'h1; cp0_epc = 32'hdeadbeef;
        cycle();
        exc_valid = 1'b0;
        repeat (2) cycle();
        check("eret_done", 32'(flush_o[0]), 32'h0);
        sex = 1'b0;
        cycle();

        // Stall request and exception in the same cycle.
        smem = 1'b1; exc_valid = 1'b1; excepttype = 32'h5;
        cycle();
        exc_valid = 1'b0;
        cycle();
        smem = 1'b0;
        repeat (4) cycle();

        // Watchdog: interrupted run, full run, then clear.
        sif = 1'b1;
        repeat (3) cycle();
        sif = 1'b0;
        cycle();
        sif = 1'b1;
        repeat (6) cycle();
        check("wd_flag", 32'(to_o[0]), 32'h1);
        sif = 1'b0; timeout_clr = 1'b1;
        cycle();
        timeout_clr = 1'b0;
        cycle();

        // Async reset in the middle of a flush.
        exc_valid = 1'b1; excepttype = 32'h1;
        cycle();
        exc_valid = 1'b0;
        cycle();
        async_reset();
        sid = 1'b1;
        cycle();
        sid = 1'b0;
        cycle();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0)
                {smem, sex, sid, sif} = 4'($urandom) & (($urandom_range(1) == 1) ? 4'b0001 : 4'b1111);
            exc_valid   = ($urandom_range(15) == 0);
            excepttype  = ($urandom_range(1) == 1) ? 32'h0000000e : 32'($urandom);
            cp0_epc     = 32'($urandom);
            timeout_clr = ($urandom_range(9) == 0);
            if ($urandom_range(400) == 0) async_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
